// File: rtl/present_pkg.sv
// Shared types and constants for the falling-present object stage.
//   present_state_t : lifecycle of one present (IDLE, FALLING, LANDED, BLINK)
//   present_type_t  : 2-bit present kind (life, speed, freeze, score)
//   TYPE_COLOR      : RGB332 colour per present type, indexed by type
package present_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned CMP_W   = COORD_W + 1;
  localparam int unsigned TIMER_W = 8;
  localparam int unsigned RGB_W   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FALLING = 2'd1,
    LANDED  = 2'd2,
    BLINK   = 2'd3
  } present_state_t;

  typedef enum logic [1:0] {
    TYPE_LIFE   = 2'd0,
    TYPE_SPEED  = 2'd1,
    TYPE_FREEZE = 2'd2,
    TYPE_SCORE  = 2'd3
  } present_type_t;

  // Element [n] is the colour of type n.
  localparam logic [3:0][RGB_W-1:0] TYPE_COLOR = {8'hFC, 8'h03, 8'h1C, 8'hE0};

endpackage

// File: rtl/present_frame_timer.sv
// Frame-tick counter shared by the LANDED and BLINK phases.
// Ports:
//   clk, resetN  : clock, synchronous active-low reset
//   clr          : clear counter to 0 (wins over en)
//   en           : increment by one (driven from a frame tick)
//   term         : terminal count to compare against
//   term_c       : counter currently equals term
//   blink_off_c  : counter bit 3, high during the dark half of each blink period
module present_frame_timer
  import present_pkg::*;
(
  input  logic               clk,
  input  logic               resetN,
  input  logic               clr,
  input  logic               en,
  input  logic [TIMER_W-1:0] term,
  output logic               term_c,
  output logic               blink_off_c
);

  logic [TIMER_W-1:0] count_q, count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term_c      = (count_q == term);
  assign blink_off_c = count_q[3];

endmodule

// File: rtl/present_controller.sv
// One falling present: spawn, fall under gravity, land, linger, blink, expire,
// or get collected by the player. Produces the per-pixel draw request and colour
// for the downstream present priority mux.
// Optional build macro PRESENT_SWAY_EN adds a 1-pixel zig-zag while falling.
// Ports:
//   clk, resetN      : clock, synchronous active-low reset
//   startOfFrame     : one-cycle frame tick (position/timers only move on it)
//   pixelX, pixelY   : current scan coordinate
//   spawnReq/X/Type  : spawn request, left X and present type (honoured in IDLE)
//   collisionPlayer  : player overlaps this present
//   presentRequest   : draw request, 1 clk after pixelX/pixelY
//   presentRGB       : RGB332 colour, 0 when not requesting
//   collected        : one-cycle pulse when the player picks the present up
//   collectedType    : type of the collected present
//   active           : present exists (state != IDLE)
module present_controller
  import present_pkg::*;
#(
  parameter int unsigned SIZE         = 16,
  parameter int unsigned FLOOR_Y      = 400,
  parameter int unsigned FALL_SPEED   = 2,
  parameter int unsigned LAND_FRAMES  = 180,
  parameter int unsigned BLINK_FRAMES = 120,
  parameter int unsigned SCREEN_W     = 640
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               spawnReq,
  input  logic [COORD_W-1:0] spawnX,
  input  logic [1:0]         spawnType,
  input  logic               collisionPlayer,
  output logic               presentRequest,
  output logic [RGB_W-1:0]   presentRGB,
  output logic               collected,
  output logic [1:0]         collectedType,
  output logic               active
);

  localparam logic [CMP_W-1:0]   SIZE_C     = CMP_W'(SIZE);
  localparam logic [CMP_W-1:0]   FLOOR_C    = CMP_W'(FLOOR_Y);
  localparam logic [CMP_W-1:0]   SPEED_C    = CMP_W'(FALL_SPEED);
  localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(SCREEN_W - SIZE);
  localparam logic [COORD_W-1:0] Y_REST     = COORD_W'(FLOOR_Y - SIZE);
  localparam logic [TIMER_W-1:0] LAND_LAST  = TIMER_W'(LAND_FRAMES - 1);
  localparam logic [TIMER_W-1:0] BLINK_LAST = TIMER_W'(BLINK_FRAMES - 1);

  present_state_t     state_q, state_d;
  present_type_t      type_q, type_d;
  logic [COORD_W-1:0] topx_q, topx_d;
  logic [COORD_W-1:0] topy_q, topy_d;
  logic               present_request_q, present_request_d;
  logic [RGB_W-1:0]   present_rgb_q, present_rgb_d;
  logic               collected_q, collected_d;
  logic [1:0]         collected_type_q, collected_type_d;
  logic               active_q, active_d;

`ifdef PRESENT_SWAY_EN
  logic [1:0]         sway_cnt_q, sway_cnt_d;
  logic               sway_left_q, sway_left_d;
`endif

  logic               tmr_clr_c, tmr_en_c, tmr_term_c, blink_off_c;
  logic [TIMER_W-1:0] tmr_term_val_c;
  logic [CMP_W-1:0]   y_next_c;
  logic               inside_c, visible_c;

  assign tmr_term_val_c = (state_q == BLINK) ? BLINK_LAST : LAND_LAST;

  present_frame_timer u_timer (
    .clk         (clk),
    .resetN      (resetN),
    .clr         (tmr_clr_c),
    .en          (tmr_en_c),
    .term        (tmr_term_val_c),
    .term_c      (tmr_term_c),
    .blink_off_c (blink_off_c)
  );

  // 12-bit fall step so the floor compare cannot wrap.
  assign y_next_c = {1'b0, topy_q} + SPEED_C;

  // Lifecycle next-state; collision beats the frame tick in the same cycle.
  always_comb begin
    state_d          = state_q;
    type_d           = type_q;
    topx_d           = topx_q;
    topy_d           = topy_q;
    collected_d      = 1'b0;
    collected_type_d = collected_type_q;
    tmr_clr_c        = 1'b0;
    tmr_en_c         = 1'b0;
`ifdef PRESENT_SWAY_EN
    sway_cnt_d       = sway_cnt_q;
    sway_left_d      = sway_left_q;
`endif
    if (state_q != IDLE && collisionPlayer) begin
      collected_d      = 1'b1;
      collected_type_d = type_q;
      tmr_clr_c        = 1'b1;
      state_d          = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (spawnReq) begin
            topx_d  = (spawnX > X_MAX) ? X_MAX : spawnX;
            topy_d  = '0;
            type_d  = present_type_t'(spawnType);
            state_d = FALLING;
`ifdef PRESENT_SWAY_EN
            // First sway step goes left.
            sway_cnt_d  = 2'd0;
            sway_left_d = 1'b1;
`endif
          end
        end
        FALLING: begin
          if (startOfFrame) begin
            if (y_next_c + SIZE_C >= FLOOR_C) begin
              topy_d    = Y_REST;
              tmr_clr_c = 1'b1;
              state_d   = LANDED;
            end else begin
              topy_d = y_next_c[COORD_W-1:0];
            end
`ifdef PRESENT_SWAY_EN
            // Every 4th tick try a 1-pixel step; direction alternates even if blocked.
            sway_cnt_d = sway_cnt_q + 2'd1;
            if (sway_cnt_q == 2'd3) begin
              sway_left_d = ~sway_left_q;
              if (sway_left_q) begin
                if (topx_q != '0) topx_d = topx_q - COORD_W'(1);
              end else begin
                if (topx_q < X_MAX) topx_d = topx_q + COORD_W'(1);
              end
            end
`endif
          end
        end
        LANDED: begin
          if (startOfFrame) begin
            if (tmr_term_c) begin
              tmr_clr_c = 1'b1;
              state_d   = BLINK;
            end else begin
              tmr_en_c = 1'b1;
            end
          end
        end
        BLINK: begin
          if (startOfFrame) begin
            if (tmr_term_c) begin
              tmr_clr_c = 1'b1;
              state_d   = IDLE;
            end else begin
              tmr_en_c = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pixel hit test against the current (frame-stable) position.
  always_comb begin
    inside_c = ({1'b0, pixelX} >= {1'b0, topx_q}) &&
               ({1'b0, pixelX} <  {1'b0, topx_q} + SIZE_C) &&
               ({1'b0, pixelY} >= {1'b0, topy_q}) &&
               ({1'b0, pixelY} <  {1'b0, topy_q} + SIZE_C);
    unique case (state_q)
      FALLING, LANDED: visible_c = 1'b1;
      BLINK:           visible_c = ~blink_off_c;
      default:         visible_c = 1'b0;
    endcase
    present_request_d = inside_c && visible_c;
    present_rgb_d     = present_request_d ? TYPE_COLOR[type_q] : '0;
    active_d          = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q           <= IDLE;
      type_q            <= TYPE_LIFE;
      topx_q            <= '0;
      topy_q            <= '0;
      present_request_q <= 1'b0;
      present_rgb_q     <= '0;
      collected_q       <= 1'b0;
      collected_type_q  <= '0;
      active_q          <= 1'b0;
    end else begin
      state_q           <= state_d;
      type_q            <= type_d;
      topx_q            <= topx_d;
      topy_q            <= topy_d;
      present_request_q <= present_request_d;
      present_rgb_q     <= present_rgb_d;
      collected_q       <= collected_d;
      collected_type_q  <= collected_type_d;
      active_q          <= active_d;
    end
  end

`ifdef PRESENT_SWAY_EN
  always_ff @(posedge clk) begin
    if (!resetN) begin
      sway_cnt_q  <= '0;
      sway_left_q <= 1'b1;
    end else begin
      sway_cnt_q  <= sway_cnt_d;
      sway_left_q <= sway_left_d;
    end
  end
`endif

  assign presentRequest = present_request_q;
  assign presentRGB     = present_rgb_q;
  assign collected      = collected_q;
  assign collectedType  = collected_type_q;
  assign active         = active_q;

endmodule

// File: tb/tb_present_controller.sv
// Directed bench for present_controller with default parameters.
module tb_present_controller;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        spawnReq = 1'b0;
  logic [10:0] spawnX = '0;
  logic [1:0]  spawnType = '0;
  logic        collisionPlayer = 1'b0;
  logic        presentRequest;
  logic [7:0]  presentRGB;
  logic        collected;
  logic [1:0]  collectedType;
  logic        active;

  int checks = 0;
  int errors = 0;
  int collect_seen = 0;

  present_controller dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .spawnReq        (spawnReq),
    .spawnX          (spawnX),
    .spawnType       (spawnType),
    .collisionPlayer (collisionPlayer),
    .presentRequest  (presentRequest),
    .presentRGB      (presentRGB),
    .collected       (collected),
    .collectedType   (collectedType),
    .active          (active)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (collected) collect_seen++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic spawn(input int x, input int t);
    spawnX    = 11'(x);
    spawnType = 2'(t);
    spawnReq  = 1'b1;
    step();
    spawnReq  = 1'b0;
  endtask

  task automatic probe(input int x, input int y, output logic req, output logic [7:0] rgb);
    pixelX = 11'(x);
    pixelY = 11'(y);
    step();
    req = presentRequest;
    rgb = presentRGB;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    step();
    step();
    checks++;
    if ({presentRequest, presentRGB, collected, collectedType, active} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b rgb=%h col=%b ctype=%0d act=%b expected all 0",
               presentRequest, presentRGB, collected, collectedType, active);
    end
    resetN = 1'b1;
    step();
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle active=%b expected 0", active);
    end
  endtask

  task automatic test_spawn_fall();
    logic req;
    logic [7:0] rgb;
    spawn(100, 1);
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL spawn_active got %b expected 1", active); end
    probe(100, 0, req, rgb);
    checks++;
    if (req !== 1'b1 || rgb !== 8'h1C) begin errors++; $display("FAIL spawn_top0 got %b/%h expected 1/1c", req, rgb); end
    probe(99, 0, req, rgb);
    checks++;
    if (req !== 1'b0 || rgb !== 8'h00) begin errors++; $display("FAIL spawn_left_edge got %b/%h expected 0/00", req, rgb); end
    frame();
    probe(100, 1, req, rgb);
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL fall1_above got %b expected 0", req); end
    probe(115, 17, req, rgb);
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL fall1_corner got %b expected 1", req); end
    frames(190);
    probe(108, 382, req, rgb);
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL fall191_top got %b expected 1", req); end
    probe(108, 381, req, rgb);
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL fall191_above got %b expected 0", req); end
    frame();
    probe(108, 390, req, rgb);
    checks++;
    if (req !== 1'b1 || rgb !== 8'h1C) begin errors++; $display("FAIL landed_pixel got %b/%h expected 1/1c", req, rgb); end
    probe(108, 383, req, rgb);
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL landed_above got %b expected 0", req); end
    probe(108, 399, req, rgb);
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL landed_bottom got %b expected 1", req); end
    probe(108, 400, req, rgb);
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL landed_floor got %b expected 0", req); end
  endtask

  task automatic test_expiry();
    logic req;
    logic [7:0] rgb;
    int base;
    base = collect_seen;
    frames(179);
    probe(108, 390, req, rgb);
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL landed_last got %b expected 1", req); end
    frames(8);
    probe(108, 390, req, rgb);
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL blink7_on got %b expected 1", req); end
    frame();
    probe(108, 390, req, rgb);
    checks++;
    if (req !== 1'b0 || rgb !== 8'h00) begin errors++; $display("FAIL blink8_off got %b/%h expected 0/00", req, rgb); end
    frames(8);
    probe(108, 390, req, rgb);
    checks++;
    if (req !== 1'b1 || rgb !== 8'h1C) begin errors++; $display("FAIL blink16_on got %b/%h expected 1/1c", req, rgb); end
    frames(8);
    probe(108, 390, req, rgb);
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL blink24_off got %b expected 0", req); end
    frames(95);
    probe(108, 390, req, rgb);
    checks++;
    if (req !== 1'b1 || active !== 1'b1) begin
      errors++; $display("FAIL blink119 got req=%b act=%b expected 1/1", req, active);
    end
    frame();
    probe(108, 390, req, rgb);
    checks++;
    if (req !== 1'b0 || active !== 1'b0) begin
      errors++; $display("FAIL expired got req=%b act=%b expected 0/0", req, active);
    end
    checks++;
    if (collect_seen !== base) begin
      errors++; $display("FAIL expiry_no_collect got %0d pulses expected 0", collect_seen - base);
    end
  endtask

  task automatic test_collect_tick();
    logic req;
    logic [7:0] rgb;
    spawn(200, 2);
    frames(3);
    probe(200, 6, req, rgb);
    checks++;
    if (req !== 1'b1 || rgb !== 8'h03) begin errors++; $display("FAIL freeze_pos got %b/%h expected 1/03", req, rgb); end
    collisionPlayer = 1'b1;
    startOfFrame    = 1'b1;
    step();
    collisionPlayer = 1'b0;
    startOfFrame    = 1'b0;
    checks++;
    if (collected !== 1'b1 || collectedType !== 2'd2 || active !== 1'b0) begin
      errors++; $display("FAIL collect_pulse got col=%b ctype=%0d act=%b expected 1/2/0",
                         collected, collectedType, active);
    end
    probe(200, 6, req, rgb);
    checks++;
    if (collected !== 1'b0 || req !== 1'b0) begin
      errors++; $display("FAIL collect_after got col=%b req=%b expected 0/0", collected, req);
    end
    collisionPlayer = 1'b1;
    step();
    step();
    collisionPlayer = 1'b0;
    checks++;
    if (collected !== 1'b0 || active !== 1'b0) begin
      errors++; $display("FAIL idle_collision got col=%b act=%b expected 0/0", collected, active);
    end
  endtask

  task automatic test_clamp_ignore();
    logic req;
    logic [7:0] rgb;
    spawn(635, 3);
    probe(624, 0, req, rgb);
    checks++;
    if (req !== 1'b1 || rgb !== 8'hFC) begin errors++; $display("FAIL clamp_left got %b/%h expected 1/fc", req, rgb); end
    probe(623, 0, req, rgb);
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL clamp_outside got %b expected 0", req); end
    probe(639, 15, req, rgb);
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL clamp_right got %b expected 1", req); end
    spawn(10, 0);
    probe(624, 0, req, rgb);
    checks++;
    if (req !== 1'b1 || rgb !== 8'hFC) begin errors++; $display("FAIL ignore_spawn got %b/%h expected 1/fc", req, rgb); end
    probe(10, 0, req, rgb);
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL ignore_newpos got %b expected 0", req); end
  endtask

  task automatic test_reset_mid();
    logic req;
    logic [7:0] rgb;
    frames(192 + 180 + 2);
    pixelX = 11'd630;
    pixelY = 11'd390;
    resetN = 1'b0;
    #3;
    resetN = 1'b1;
    step();
    checks++;
    if (active !== 1'b1 || presentRequest !== 1'b1 || presentRGB !== 8'hFC) begin
      errors++; $display("FAIL reset_glitch got act=%b req=%b rgb=%h expected 1/1/fc",
                         active, presentRequest, presentRGB);
    end
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    checks++;
    if ({presentRequest, presentRGB, collected, collectedType, active} !== 13'd0) begin
      errors++; $display("FAIL reset_mid got req=%b rgb=%h col=%b ctype=%0d act=%b expected all 0",
                         presentRequest, presentRGB, collected, collectedType, active);
    end
    probe(630, 390, req, rgb);
    checks++;
    if (req !== 1'b0 || active !== 1'b0) begin
      errors++; $display("FAIL reset_mid_idle got req=%b act=%b expected 0/0", req, active);
    end
  endtask

  task automatic test_back_to_back();
    logic req;
    logic [7:0] rgb;
    spawn(50, 0);
    probe(50, 0, req, rgb);
    checks++;
    if (req !== 1'b1 || rgb !== 8'hE0 || active !== 1'b1) begin
      errors++; $display("FAIL respawn got %b/%h act=%b expected 1/e0/1", req, rgb, active);
    end
  endtask

`ifdef PRESENT_SWAY_EN
  task automatic test_sway();
    logic req;
    logic [7:0] rgb;
    spawn(0, 0);
    frames(4);
    probe(0, 8, req, rgb);
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL sway_skip got %b expected 1", req); end
    frames(4);
    probe(0, 16, req, rgb);
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL sway_right_old got %b expected 0", req); end
    probe(16, 16, req, rgb);
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL sway_right_new got %b expected 1", req); end
    frames(4);
    probe(0, 24, req, rgb);
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL sway_back got %b expected 1", req); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PRESENT_SWAY_EN
    test_sway();
`else
    test_spawn_fall();
    test_expiry();
    test_collect_tick();
    test_clamp_ignore();
    test_reset_mid();
    test_back_to_back();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
